// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit, one shift-add or restoring shift-subtract step per CALC cycle.
// Signed MULT/DIV support is compiled in only when MULT_DIV_SIGNED_EN is defined.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic            div_q, sgn_q, sgn_in;
    logic [W-1:0]    a_q, b_q, a_mag, b_mag;
    logic [2*W-1:0]  acc, acc_step;
    logic [W:0]      mul_sum, div_shift;
    logic            div_ge;
    logic [W-1:0]    div_rem, res_hi, res_lo;

    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic s);
        mag = (s && x[W-1]) ? -x : x;
    endfunction

`ifdef MULT_DIV_SIGNED_EN
    assign sgn_in = op[0];
`else
    logic unused_op;
    assign sgn_in = 1'b0;
    assign unused_op = op[0];
`endif

    assign busy  = state != IDLE;
    assign a_mag = mag(a_q, sgn_q);
    assign b_mag = mag(b_q, sgn_q);

    // Multiply keeps {partial product, multiplier}; divide keeps {remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_mag} : '0);
    assign div_shift = {acc[2*W-1:W], acc[W-1]};
    assign div_ge    = div_shift >= {1'b0, b_mag};
    assign div_rem   = div_ge ? div_shift[W-1:0] - b_mag : div_shift[W-1:0];
    assign acc_step  = div_q ? {div_rem, acc[W-2:0], div_ge} : {mul_sum, acc[W-1:1]};

    always_comb begin
        res_hi = acc[2*W-1:W];
        res_lo = acc[W-1:0];
`ifdef MULT_DIV_SIGNED_EN
        if (!div_q && sgn_q && (a_q[W-1] ^ b_q[W-1])) {res_hi, res_lo} = -acc;
        if (div_q && sgn_q && (a_q[W-1] ^ b_q[W-1])) res_lo = -acc[W-1:0];
        if (div_q && sgn_q && a_q[W-1]) res_hi = -acc[2*W-1:W];
`endif
        // Divide by zero returns the dividend untouched, regardless of signedness
        if (div_q && b_q == '0) begin
            res_hi = a_q;
            res_lo = '1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? CALC : IDLE;
            CALC:    state_next = (cnt == CW'(W - 1)) ? FINISH : CALC;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            div_q <= 1'b0;
            sgn_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cnt   <= '0;
                    div_q <= op[1];
                    sgn_q <= sgn_in;
                    a_q   <= src_a;
                    b_q   <= src_b;
                    acc   <= {{W{1'b0}}, op[1] ? mag(src_a, sgn_in) : mag(src_b, sgn_in)};
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: random and directed stimulus against a cycle-level reference model of mult_div_unit.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0, src_b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          pass_cnt = 0, total = 0;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        int sa, sb;
`ifdef MULT_DIV_SIGNED_EN
        sgn = o[1] ? o[0] : o[0];
`else
        sgn = 1'b0;
`endif
        sa = a;
        sb = b;
        if (!o[1]) return sgn ? 64'(longint'(sa) * longint'(sb)) : 64'(a) * 64'(b);
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    // Reference model: an accepted start finishes 33 edges later
    logic        m_busy, m_done;
    logic [31:0] m_hi, m_lo, m_a, m_b;
    logic [1:0]  m_op;
    int          remain;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_hi = 0; m_lo = 0; remain = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    m_op = op; m_a = src_a; m_b = src_b; m_busy = 1; remain = 33;
                end
            end else begin
                remain--;
                if (remain == 0) begin
                    {m_hi, m_lo} = ref_result(m_op, m_a, m_b);
                    m_done = 1;
                    m_busy = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
    end

    // Called at posedge+3; returns at posedge+3 of the cycle where done is high (or after reset release)
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input int rst_at,
                          output logic [31:0] rh, output logic [31:0] rl, output int n);
        op = o; src_a = a; src_b = b; start = 1;
        @(posedge clk);
        #3;
        start = 0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
        n = 0; rh = 'x; rl = 'x;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            start = 0;
            if (done) break;
            if (n == poke_at) begin
                start = 1; op = 2'($urandom); src_a = $urandom; src_b = $urandom_range(1, 9);
            end
            if (n == rst_at) begin
                #2;
                rst = 1;
                #1;
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_hi", 64'(hi), 64'(0));
                chk("rst_lo", 64'(lo), 64'(0));
                @(posedge clk);
                #3;
                rst = 0;
                return;
            end
        end
        start = 0;
        if (n >= 100) chk("done_timeout", 64'(done), 64'(1));
        rh = hi; rl = lo;
        #2;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] rh, rl, a, b;
        logic [63:0] e;
        logic [1:0]  o;
        int n;
        repeat (2) @(posedge clk);
        #3;
        rst = 0;
        @(posedge clk);
        #3;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, rh, rl, n);
        chk("multu_lat", 64'(n), 64'(33));
        chk("multu_max", {rh, rl}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, 0, rh, rl, n);
`ifdef MULT_DIV_SIGNED_EN
        chk("mult_neg", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, rh, rl, n);
        chk("div_neg", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, rh, rl, n);
        chk("div_ovf", {rh, rl}, 64'h0000_0000_8000_0000);
`else
        chk("mult_neg", {rh, rl}, 64'h0000_0006_FFFF_FFEB);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, rh, rl, n);
        chk("div_as_divu", {rh, rl}, 64'h0000_0001_7FFF_FFFC);
`endif
        run_op(2'b10, 32'h1234_5678, 32'h0, 0, 0, rh, rl, n);
        chk("divu_zero_lat", 64'(n), 64'(33));
        chk("divu_zero", {rh, rl}, 64'h1234_5678_FFFF_FFFF);
        run_op(2'b10, 32'd100, 32'd7, 10, 0, rh, rl, n);
        chk("divu_ignore", {rh, rl}, {32'd2, 32'd14});
        run_op(2'b10, 32'd100, 32'd7, 0, 15, rh, rl, n);
        run_op(2'b00, 32'd6, 32'd7, 0, 0, rh, rl, n);
        chk("multu_after_rst", {rh, rl}, {32'd0, 32'd42});
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            a = pick();
            b = pick();
            e = ref_result(o, a, b);
            run_op(o, a, b, (i % 5 == 0) ? 7 : 0, 0, rh, rl, n);
            chk("rand_lat", 64'(n), 64'(33));
            chk("rand_res", {rh, rl}, e);
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the operand and result width; legal values are even and at least 8.
REQ-002 Port clk, input, 1 bit, is the single clock; every register updates on its rising edge.
REQ-003 Port rst, input, 1 bit, is an asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit, requests an operation; it is sampled only in IDLE.
REQ-005 Port op, input, 2 bits, selects the operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 Port src_a, input, DATA_WIDTH bits, is the multiplicand or dividend (fed from register file read_data_1).
REQ-007 Port src_b, input, DATA_WIDTH bits, is the multiplier or divisor (fed from register file read_data_2).
REQ-008 Port busy, output, 1 bit, is high whenever state is not IDLE.
REQ-009 Port done, output, 1 bit, is a registered one-cycle completion pulse.
REQ-010 Port hi, output, DATA_WIDTH bits, is the HI result register.
REQ-011 Port lo, output, DATA_WIDTH bits, is the LO result register.

Function
REQ-012 The state machine SHALL have three states: IDLE, CALC and FINISH.
- IDLE -> CALC on start=1.
- CALC -> FINISH after exactly DATA_WIDTH CALC cycles.
- FINISH -> IDLE unconditionally.
REQ-013 On the accepting edge, src_a, src_b and op SHALL be captured; later input changes do not affect the operation in flight.
REQ-014 start SHALL be ignored while busy=1; there is no queueing and no error flag.
REQ-015 Each CALC cycle SHALL perform one iteration:
- multiply: one shift-add step on the 2*DATA_WIDTH accumulator;
- divide: one restoring shift-subtract step.
REQ-016 Latency:
- start sampled at edge k;
- busy=1 from edge k through edge k+DATA_WIDTH+1;
- done=1 and hi/lo updated for exactly the cycle following edge k+DATA_WIDTH+1.
REQ-017 Multiply results SHALL be hi = upper DATA_WIDTH bits and lo = lower DATA_WIDTH bits of the full 2*DATA_WIDTH product.
REQ-018 Divide results SHALL be lo = quotient and hi = remainder.
REQ-019 Signed operations SHALL iterate on operand magnitudes and then sign-fix in FINISH:
- product negated when operand signs differ;
- quotient negated when operand signs differ;
- remainder takes the dividend's sign.
REQ-020 Divide by zero (src_b=0, DIVU or DIV) SHALL complete with normal latency and give lo = all ones, hi = src_a unmodified.
REQ-021 Signed overflow, DIV of the most-negative value by -1, SHALL give lo = most-negative value and hi = 0.
REQ-022 hi and lo SHALL hold their last result until the next FINISH; intermediate iteration values are never visible on hi or lo.
REQ-023 A new start SHALL be accepted in the cycle after done, giving back-to-back operations every DATA_WIDTH+2 cycles.

Reset
REQ-024 Asserting rst SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0 and clear the iteration counter and accumulators.
REQ-025 Reset mid-operation SHALL abandon the operation with no done pulse; the first edge with rst=0 and start=1 begins a fresh operation.

Configuration
REQ-026 The macro MULT_DIV_SIGNED_EN controls signed support.
- Defined: MULT and DIV are signed per REQ-019 and REQ-021.
- Undefined: op[0] is ignored, MULT behaves as MULTU, DIV behaves as DIVU, and the sign-fix logic is not compiled.

Verification (DATA_WIDTH=32)
REQ-027 MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> done after 33 edges; hi=0xFFFFFFFE, lo=0x00000001.
REQ-028 MULT, a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; without MULT_DIV_SIGNED_EN -> hi=0x00000006, lo=0xFFFFFFEB.
REQ-029 DIV, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-030 DIVU, a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, with normal latency.
REQ-031 DIVU 100/7 in flight, start pulsed at cycle 10 with different operands -> ignored; result lo=14, hi=2.
REQ-032 Reset pulsed at cycle 15 of an operation -> busy=0 and hi=lo=0 at once, no done pulse; a following MULTU 6*7 -> lo=42, hi=0.
